// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller: instruction/address
// widths, the opcode map and the controller state encoding.
package fetch_pkg;

    localparam int IW = 9;
    localparam int AW = 8;

    localparam logic [IW-1:0] NOP = 9'h000;

    typedef enum logic [3:0] {
        OP_LTH  = 4'b1011,
        OP_LTL  = 4'b1100,
        OP_BLT  = 4'b1101,
        OP_BEQ  = 4'b1110,
        OP_HALT = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BUBBLE,
        HALTED
    } state_t;

endpackage

// File: rtl/fetch_decode.sv
// Opcode classification of the instruction register; purely combinational,
// every opcode not listed here is a pass-through instruction.
module fetch_decode
    import fetch_pkg::*;
(
    input  logic [IW-1:0] ir,
    output logic          is_halt,
    output logic          is_beq,
    output logic          is_blt,
    output logic          is_ltl,
    output logic          is_lth
);

    logic [3:0] op;
    logic       unused_operand;

    assign op = ir[IW-1:IW-4];

    assign is_halt = (op == OP_HALT);
    assign is_beq  = (op == OP_BEQ);
    assign is_blt  = (op == OP_BLT);
    assign is_ltl  = (op == OP_LTL);
    assign is_lth  = (op == OP_LTH);

    // Operand bits belong to the controller (target nibble loads).
    assign unused_operand = ^ir[IW-5:0];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch/issue controller: registers the fetched word, issues or squashes it,
// raises branch requests with a one-cycle bubble and freezes IF on HALT.
//
//   state  | meaning
//   IDLE   | first cycle after reset, ir not yet valid, issue NOP
//   RUN    | ir issued; branches, target loads and HALT take effect
//   BUBBLE | cycle after a branch, fetched word squashed
//   HALTED | IF frozen, NOP issued until reset
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] core,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] instr,
    output logic          branchsig,
    output logic          branchtype,
    output logic [AW-1:0] BranchOut,
    output logic          halt,
    output logic [7:0]    branch_count
);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ir;
    logic [AW-1:0] target;
    logic          run;
    logic          is_halt;
    logic          is_beq;
    logic          is_blt;
    logic          is_ltl;
    logic          is_lth;

    fetch_decode u_decode (
        .ir      (ir),
        .is_halt (is_halt),
        .is_beq  (is_beq),
        .is_blt  (is_blt),
        .is_ltl  (is_ltl),
        .is_lth  (is_lth)
    );

    assign imem_addr = core;
    assign BranchOut = target;
    assign halt      = (state == HALTED);
    assign run       = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        instr      = NOP;
        branchsig  = 1'b0;
        branchtype = 1'b0;
        case (state)
            IDLE:   state_nxt = RUN;
            RUN: begin
                instr = ir;
                if (is_beq || is_blt) begin
                    state_nxt  = BUBBLE;
                    branchsig  = 1'b1;
                    branchtype = is_beq;
                end else if (is_halt) begin
                    state_nxt = HALTED;
                end
            end
            BUBBLE: state_nxt = RUN;
            HALTED: state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir           <= NOP;
            target       <= '0;
            branch_count <= '0;
        end else begin
            if (state != HALTED) begin
                ir <= imem_data;
            end
            // Target loads only commit from an issued (RUN) instruction.
            if (run && is_ltl) begin
                target[3:0] <= ir[3:0];
            end
            if (run && is_lth) begin
                target[7:4] <= ir[3:0];
            end
            if (branchsig && (branch_count != 8'hFF)) begin
                branch_count <= branch_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// instruction streams checked every cycle against an issue-level model.
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] core = 8'h00;
    logic [8:0] imem_data = 9'h000;
    logic [7:0] imem_addr;
    logic [8:0] instr;
    logic       branchsig;
    logic       branchtype;
    logic [7:0] BranchOut;
    logic       halt;
    logic [7:0] branch_count;

    fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .core         (core),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr        (instr),
        .branchsig    (branchsig),
        .branchtype   (branchtype),
        .BranchOut    (BranchOut),
        .halt         (halt),
        .branch_count (branch_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Issue-level model: the word presented in one cycle is issued in the
    // next, unless that next cycle is the first after reset, follows a
    // taken branch, or the stream has already halted.
    int         m_cycles;
    bit         m_after_branch;
    bit         m_halted;
    logic [8:0] m_prev;
    logic [7:0] m_target;
    int         m_branches;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return (m_cycles > 0) && !m_after_branch && !m_halted;
    endfunction

    function automatic bit m_is_branch();
        return m_valid() && (m_prev[8:5] == 4'hE || m_prev[8:5] == 4'hD);
    endfunction

    function automatic logic [8:0] e_instr();
        return m_valid() ? m_prev : 9'h000;
    endfunction

    function automatic logic [7:0] e_count();
        return (m_branches > 255) ? 8'hFF : 8'(m_branches);
    endfunction

    task automatic model_reset();
        m_cycles       = 0;
        m_after_branch = 1'b0;
        m_halted       = 1'b0;
        m_prev         = 9'h000;
        m_target       = 8'h00;
        m_branches     = 0;
    endtask

    task automatic model_step();
        bit         v;
        bit         br;
        logic [3:0] op;
        v  = m_valid();
        br = m_is_branch();
        op = m_prev[8:5];
        if (v && op == 4'hC) m_target[3:0] = m_prev[3:0];
        if (v && op == 4'hB) m_target[7:4] = m_prev[3:0];
        if (br) m_branches++;
        m_after_branch = br;
        if (!m_halted) m_prev = imem_data;
        if (v && op == 4'hF) m_halted = 1'b1;
        m_cycles++;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("imem_addr", imem_addr, core);
            check("instr", instr, e_instr());
            check("branchsig", branchsig, m_is_branch());
            check("branchtype", branchtype, m_is_branch() && m_prev[8:5] == 4'hE);
            check("halt", halt, m_halted);
            check("BranchOut", BranchOut, m_target);
            check("branch_count", branch_count, e_count());
        end
    end

    task automatic cycle(input logic [8:0] w);
        imem_data = w;
        core      = 8'($urandom);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int offset);
        check_en = 1'b0;
        #offset;
        reset = 1'b1;
        #1;
        check("rst_instr", instr, 9'h000);
        check("rst_branchsig", branchsig, 1'b0);
        check("rst_branchtype", branchtype, 1'b0);
        check("rst_halt", halt, 1'b0);
        check("rst_BranchOut", BranchOut, 8'h00);
        check("rst_count", branch_count, 8'h00);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        check_en = 1'b1;
    endtask

    function automatic logic [8:0] rand_word(input bit allow_halt);
        int         r;
        logic [4:0] low;
        r   = $urandom_range(99);
        low = 5'($urandom);
        if (r < 12) return {4'hC, low};
        if (r < 24) return {4'hB, low};
        if (r < 34) return {4'hE, low};
        if (r < 44) return {4'hD, low};
        if (r < 46 && allow_halt) return {4'hF, low};
        return {4'($urandom_range(10)), low};
    endfunction

    initial begin
        model_reset();
        do_reset(2);

        // Pass-through word after reset release.
        #1;
        check("r19_idle_instr", instr, 9'h000);
        cycle(9'h023);
        check("r19_run_instr", instr, 9'h023);
        check("r19_branchsig", branchsig, 1'b0);
        check("r19_halt", halt, 1'b0);

        // Target loads then BEQ, with BLT right behind it.
        cycle(9'h18F);
        cycle(9'h167);
        check("r20_target_low", BranchOut, 8'h0F);
        cycle(9'h1C0);
        check("r20_target", BranchOut, 8'h7F);
        check("r20_beq_sig", branchsig, 1'b1);
        check("r20_beq_type", branchtype, 1'b1);
        check("r20_beq_instr", instr, 9'h1C0);
        cycle(9'h1A0);
        check("r20_bubble_instr", instr, 9'h000);
        check("r21_blt_squashed", branchsig, 1'b0);
        check("r20_count", branch_count, 8'h01);
        cycle(9'h023);
        check("r21_resume_instr", instr, 9'h023);
        check("r21_count", branch_count, 8'h01);

        // HALT then frozen for 20 cycles.
        cycle(9'h1E0);
        check("r22_halt_instr", instr, 9'h1E0);
        check("r22_halt_pre", halt, 1'b0);
        cycle(rand_word(1'b1));
        check("r22_halted", halt, 1'b1);
        check("r22_halted_instr", instr, 9'h000);
        for (int i = 0; i < 20; i++) begin
            cycle(rand_word(1'b1));
            check("r22_hold_halt", halt, 1'b1);
            check("r22_hold_instr", instr, 9'h000);
        end
        do_reset(2);
        check("r22_halt_cleared", halt, 1'b0);

        // Saturating branch counter: continuous BEQ stream.
        for (int i = 0; i < 508; i++) cycle(9'h1C0);
        check("r23_count_254", branch_count, 8'hFE);
        for (int i = 0; i < 2; i++) cycle(9'h1C0);
        check("r23_count_255", branch_count, 8'hFF);
        for (int i = 0; i < 10; i++) cycle(9'h1C0);
        check("r23_count_sat", branch_count, 8'hFF);

        // Reset mid-cycle in BUBBLE, then with an LTL pending in RUN.
        do_reset(2);
        cycle(9'h1C0);
        cycle(9'h18F);
        check("r24_in_bubble", instr, 9'h000);
        do_reset(2);
        #1;
        check("r24_target_after", BranchOut, 8'h00);
        cycle(9'h18F);
        check("r24_ltl_pending", instr, 9'h18F);
        do_reset(2);
        cycle(9'h023);
        cycle(9'h023);
        check("r24_ltl_discarded", BranchOut, 8'h00);

        // Randomized streams, alternating with and without HALT words.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset(2 + seg % 3);
            for (int i = 0; i < 150; i++) cycle(rand_word(seg % 2 == 1));
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Ports, in order:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-high reset
- core  in  8  current PC from IF
- imem_addr  out  8  instruction memory address; combinationally equal to core
- imem_data  in  9  instruction word returned combinationally for imem_addr
- instr  out  9  issued instruction to decode/execute; NOP (9'h000) when squashed
- branchsig  out  1  branch request to IF
- branchtype  out  1  condition select to IF: 1 = taken when cmp==0; 0 = taken when cmp[7]==1
- BranchOut  out  8  branch target to IF
- halt  out  1  freezes the IF PC
- branch_count  out  8  number of branch requests issued, saturating

Function
REQ-003 SHALL capture imem_data into the 9-bit instruction register ir on every posedge while state is IDLE, RUN or BUBBLE; ir SHALL hold in HALTED.
REQ-004 SHALL decode opcode ir[8:5] as:
- 4'b1111 HALT
- 4'b1110 BEQ
- 4'b1101 BLT
- 4'b1100 LTL (target[3:0] <= ir[3:0])
- 4'b1011 LTH (target[7:4] <= ir[3:0])
- any other value: pass-through
REQ-005 SHALL implement FSM states IDLE, RUN, BUBBLE, HALTED with these transitions:
- IDLE -> RUN unconditionally
- RUN -> BUBBLE on BEQ/BLT
- RUN -> HALTED on HALT
- RUN -> RUN otherwise
- BUBBLE -> RUN unconditionally
- HALTED stays HALTED until reset
REQ-006 instr SHALL equal ir in RUN and NOP in IDLE, BUBBLE and HALTED.
REQ-007 branchsig SHALL be 1 only in RUN while ir is BEQ or BLT; branchtype SHALL then be 1 for BEQ and 0 for BLT, otherwise 0.
REQ-008 BranchOut SHALL drive the 8-bit target register combinationally.
REQ-009 LTL/LTH SHALL update the target register at the posedge ending their RUN cycle. A branch in the immediately following RUN cycle SHALL see the updated target.
REQ-010 LTL/LTH/HALT/BEQ/BLT in ir during IDLE or BUBBLE SHALL be squashed: no target write, no branch, no halt.
REQ-011 halt SHALL be 1 from the posedge that enters HALTED until reset. In the RUN cycle holding HALT, instr SHALL still equal the HALT word.
REQ-012 branch_count SHALL increment by 1 at each posedge where branchsig==1 and SHALL saturate at 8'hFF (no wrap to 0).
REQ-013 Branch latency: a branch issued in cycle N SHALL produce exactly one squashed cycle (N+1); the instruction at the target SHALL issue in cycle N+2.
REQ-014 Back-to-back branches SHALL be impossible; the second is always in BUBBLE and is squashed.

Reset
REQ-015 Asserting reset SHALL immediately, independent of clk, set:
- state = IDLE
- ir = NOP
- target = 8'h00
- branch_count = 8'h00
- halt = 0, branchsig = 0, branchtype = 0
- instr = NOP, BranchOut = 8'h00
REQ-016 Reset asserted mid-operation (any state, including HALTED or BUBBLE) SHALL discard pending target writes and SHALL resume via IDLE after deassertion.

Structure
REQ-017 Package fetch_pkg SHALL hold:
- opcode enum (4-bit)
- state enum
- NOP constant 9'h000
- instruction width 9 and address width 8
REQ-018 Opcode classification SHALL live in one combinational sub-module fetch_decode (ir in; is_halt, is_beq, is_blt, is_ltl, is_lth out). All state stays in fetch_ctrl.

Verification
REQ-019 Reset release then imem returns pass-through word 9'h023 -> instr NOP for 1 cycle, then 9'h023; branchsig 0; halt 0.
REQ-020 LTL 0x7F low (9'h18F) then LTH (9'h167) then BEQ -> BranchOut 8'h7F, and in the BEQ cycle branchsig=1, branchtype=1. Next cycle instr=NOP. branch_count=1.
REQ-021 BLT fetched right after BEQ -> only one branchsig pulse; BLT squashed; branch_count increments by 1.
REQ-022 HALT (9'h1E0) -> instr=9'h1E0 for one cycle, then halt=1 and instr=NOP, held for 20 cycles regardless of imem_data; reset clears halt.
REQ-023 Issue 260 branches -> branch_count stays 8'hFF after the 255th.
REQ-024 Reset asserted between clock edges in BUBBLE -> outputs reach reset values before the next posedge; target=8'h00 after release.
